// File: rtl/bp_me_wormhole_packet_decode_mem_resp.sv
// bp_me_wormhole_packet_decode_mem_resp: reassembles mem-response wormhole flits into one {data, msg} message.
// Defining BP_ME_WH_DECODE_OVERLAP_EN lets flit 0 of the next packet enter on the yumi cycle.
module bp_me_wormhole_packet_decode_mem_resp #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 7,
  parameter int cid_width_p     = 2,
  parameter int len_width_p     = 4,
  parameter int mem_hdr_width_p = 64,
  parameter int data_width_p    = 512
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [flit_width_p-1:0]                 link_data_i,
  input  logic                                    link_v_i,
  output logic                                    link_ready_o,
  output logic [mem_hdr_width_p+data_width_p-1:0] mem_resp_o,
  output logic                                    mem_resp_v_o,
  input  logic                                    mem_resp_yumi_i,
  output logic [cord_width_p-1:0]                 src_cord_o,
  output logic [cid_width_p-1:0]                  src_cid_o
);
  localparam int pkt_width_lp    = data_width_p + mem_hdr_width_p + 2*cid_width_p + 2*cord_width_p + len_width_p;
  localparam int max_flits_lp    = (pkt_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int len_off_lp      = cord_width_p;
  localparam int src_cord_off_lp = cord_width_p + len_width_p + cid_width_p;
  localparam int src_cid_off_lp  = src_cord_off_lp + cord_width_p;
  localparam int msg_off_lp      = src_cid_off_lp + cid_width_p;
  typedef enum logic [1:0] {e_ready, e_recv, e_out} state_e;
  state_e state, state_n;
  logic [len_width_p-1:0] len_r, cnt, new_len;
  logic [flit_width_p-1:0] flits [max_flits_lp];
  logic [max_flits_lp*flit_width_p-1:0] pkt;
  logic xfer, start, wr, last, unused_bits;
  assign new_len      = link_data_i[len_off_lp +: len_width_p];
  assign mem_resp_v_o = state == e_out;
`ifdef BP_ME_WH_DECODE_OVERLAP_EN
  assign link_ready_o = (state != e_out) | mem_resp_yumi_i;
`else
  assign link_ready_o = state != e_out;
`endif
  assign xfer  = link_v_i & link_ready_o;
  // outside e_recv an accepted flit is always flit 0 of a new packet
  assign start = xfer & (state != e_recv);
  assign wr    = xfer & (state == e_recv);
  assign last  = wr & (cnt == len_r);
  always_comb
    state_n = start ? (new_len == '0 ? e_out : e_recv)
            : last ? e_out
            : (mem_resp_v_o & mem_resp_yumi_i) ? e_ready
            : state;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= e_ready;
      cnt   <= '0;
      len_r <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        cnt   <= len_width_p'(1);
        len_r <= new_len;
      end else if (wr)
        cnt <= cnt + 1'b1;
    end
  // flits past the buffer never match any slot, so oversized packets drop them
  for (genvar k = 0; k < max_flits_lp; k++) begin : g_flit
    always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i)
        flits[k] <= '0;
      else if (start)
        flits[k] <= (k == 0) ? link_data_i : '0;
      else if (wr && int'(cnt) == k)
        flits[k] <= link_data_i;
    assign pkt[k*flit_width_p +: flit_width_p] = flits[k];
  end
  assign mem_resp_o  = pkt[msg_off_lp +: mem_hdr_width_p + data_width_p];
  assign src_cord_o  = pkt[src_cord_off_lp +: cord_width_p];
  assign src_cid_o   = pkt[src_cid_off_lp +: cid_width_p];
  assign unused_bits = &{1'b0, pkt};
endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_mem_resp.sv
// tb_bp_me_wormhole_packet_decode_mem_resp: directed and random packets checked against a field-level model.
module tb_bp_me_wormhole_packet_decode_mem_resp;
`ifdef BP_ME_WH_DECODE_OVERLAP_EN
  localparam bit ovl = 1'b1;
`else
  localparam bit ovl = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_i, link_v_i, link_ready_o, mem_resp_v_o, mem_resp_yumi_i;
  logic [63:0] link_data_i;
  logic [575:0] mem_resp_o;
  logic [6:0] src_cord_o;
  logic [1:0] src_cid_o;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  bp_me_wormhole_packet_decode_mem_resp #(
    .flit_width_p(64), .cord_width_p(7), .cid_width_p(2), .len_width_p(4),
    .mem_hdr_width_p(64), .data_width_p(512)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .link_data_i(link_data_i), .link_v_i(link_v_i),
    .link_ready_o(link_ready_o), .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i), .src_cord_o(src_cord_o), .src_cid_o(src_cid_o)
  );

  function automatic logic [639:0] build(input logic [6:0] cord, input logic [3:0] len, input logic [1:0] cid,
                                         input logic [6:0] scord, input logic [1:0] scid,
                                         input logic [63:0] msg, input logic [511:0] data);
    return {42'b0, data, msg, scid, scord, cid, len, cord};
  endfunction

  // a sender only transmits len+1 flits; anything beyond them must read as zero
  function automatic logic [639:0] visible(input logic [639:0] p, input int len);
    logic [639:0] r;
    r = p;
    for (int i = (len + 1) * 64; i < 640; i++) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_pkt(input logic [639:0] p, input int len, input bit gap);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      link_v_i = 1'b1;
      link_data_i = (k < 10) ? p[k*64 +: 64] : {$urandom, $urandom};
      #1;
      chk("ready_recv", link_ready_o, 1);
      if (k == len) chk("v_before_last", mem_resp_v_o, 0);
      @(posedge clk);
      if (gap && k != len) begin
        @(negedge clk);
        link_v_i = 1'b0;
        link_data_i = {$urandom, $urandom};
        @(posedge clk);
      end
    end
    @(negedge clk);
    link_v_i = 1'b0;
  endtask

  task automatic take(input logic [639:0] p, input int len, input int hold);
    logic [639:0] e;
    e = visible(p, len);
    link_v_i = !ovl;
    link_data_i = {$urandom, $urandom};
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("v_hold", mem_resp_v_o, 1);
      chk("ready_out", link_ready_o, 0);
      @(negedge clk);
    end
    #1;
    chk("v_out", mem_resp_v_o, 1);
    chk("ready_out", link_ready_o, 0);
    chk("resp", mem_resp_o, e[22 +: 576]);
    chk("src_cord", src_cord_o, e[13 +: 7]);
    chk("src_cid", src_cid_o, e[20 +: 2]);
    mem_resp_yumi_i = 1'b1;
    @(negedge clk);
    mem_resp_yumi_i = 1'b0;
    link_v_i = 1'b0;
    #1;
    chk("v_after_yumi", mem_resp_v_o, 0);
    chk("ready_after_yumi", link_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [639:0] p, p2;
    int len;
    reset_i = 1'b1;
    link_v_i = 1'b0;
    link_data_i = '0;
    mem_resp_yumi_i = 1'b0;
    #1;
    chk("rst_v", mem_resp_v_o, 0);
    chk("rst_ready", link_ready_o, 1);
    chk("rst_resp", mem_resp_o, 0);
    chk("rst_cord", src_cord_o, 0);
    chk("rst_cid", src_cid_o, 0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;

    p = build(7'h03, 4'd1, 2'd1, 7'h15, 2'd2, {$urandom, $urandom}, 512'b0);
    send_pkt(p, 1, 1'b0);
    take(p, 1, 0);
    chk("ack_data_zero", mem_resp_o[575:64], 0);

    p = build(7'h11, 4'd9, 2'd0, 7'h2a, 2'd3, {$urandom, $urandom}, {512{1'b1}});
    send_pkt(p, 9, 1'b0);
    take(p, 9, 0);
    p = build(7'h05, 4'd2, 2'd2, 7'h33, 2'd1, {$urandom, $urandom}, 512'hDEADBEEF_CAFEF00D);
    send_pkt(p, 2, 1'b0);
    take(p, 2, 0);
    chk("rd8_data_lo", mem_resp_o[127:64], 64'hDEADBEEF_CAFEF00D);
    chk("rd8_data_hi", mem_resp_o[575:128], 0);

    p = build(7'h7f, 4'd9, 2'd3, 7'h01, 2'd0, {$urandom, $urandom}, rnd512());
    send_pkt(p, 9, 1'b1);
    take(p, 9, 5);

    p = build(7'h0a, 4'd9, 2'd1, 7'h44, 2'd2, {$urandom, $urandom}, rnd512());
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      link_v_i = 1'b1;
      link_data_i = p[k*64 +: 64];
      @(posedge clk);
    end
    @(negedge clk);
    link_v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("abort_v", mem_resp_v_o, 0);
    chk("abort_ready", link_ready_o, 1);
    chk("abort_resp", mem_resp_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_v", mem_resp_v_o, 0);
    end
    p = build(7'h12, 4'd1, 2'd0, 7'h56, 2'd1, {$urandom, $urandom}, 512'b0);
    send_pkt(p, 1, 1'b0);
    take(p, 1, 0);

    p = build(7'h21, 4'd12, 2'd2, 7'h6b, 2'd3, {$urandom, $urandom}, rnd512());
    send_pkt(p, 12, 1'b0);
    take(p, 12, 1);

    repeat (20) begin
      len = $urandom_range(0, 12);
      p = build(7'($urandom), 4'(len), 2'($urandom), 7'($urandom), 2'($urandom), {$urandom, $urandom}, rnd512());
      send_pkt(p, len, 1'($urandom));
      take(p, len, $urandom_range(0, 3));
    end

`ifdef BP_ME_WH_DECODE_OVERLAP_EN
    p  = build(7'h01, 4'd1, 2'd1, 7'h10, 2'd1, {$urandom, $urandom}, 512'b0);
    p2 = build(7'h02, 4'd1, 2'd2, 7'h20, 2'd2, {$urandom, $urandom}, 512'b0);
    send_pkt(p, 1, 1'b0);
    #1;
    chk("ovl_v1", mem_resp_v_o, 1);
    chk("ovl_resp1", mem_resp_o, visible(p, 1) >> 22);
    mem_resp_yumi_i = 1'b1;
    link_v_i = 1'b1;
    link_data_i = p2[63:0];
    #1;
    chk("ovl_ready_yumi", link_ready_o, 1);
    @(negedge clk);
    mem_resp_yumi_i = 1'b0;
    link_data_i = p2[127:64];
    #1;
    chk("ovl_v_gap", mem_resp_v_o, 0);
    @(negedge clk);
    link_v_i = 1'b0;
    take(p2, 1, 0);
`else
    p2 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_me_wormhole_packet_decode_mem_resp.md
# bp_me_wormhole_packet_decode_mem_resp

Receive-side deserializer for memory responses on the mem wormhole network. Accepts a stream of flits from the network link, reassembles one packet per response using the packet's `len` field, and presents the enclosed `bp_cce_mem_msg_s` (header plus data) to the consumer with a valid/yumi handshake. Sits between the wormhole router's local ejection port and the LCE/CCE memory-response consumer, and pairs with the mem-response packet encoder at the far end.

## Interface
Parameters:
- `flit_width_p`, "inv", link flit width in bits
- `cord_width_p`, "inv", width of the destination and source coordinate fields
- `cid_width_p`, "inv", width of the destination and source cid fields
- `len_width_p`, "inv", width of the `len` field
- `mem_hdr_width_p`, "inv", mem message width minus data (`cce_mem_msg_width_lp - cce_block_width_p`)
- `data_width_p`, "inv", `cce_block_width_p`
- Derived: `pkt_width_lp = data_width_p + mem_hdr_width_p + 2*cid_width_p + 2*cord_width_p + len_width_p`; `max_flits_lp = ceil(pkt_width_lp / flit_width_p)`

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; asynchronous, active-high
- `link_data_i`  in  flit_width_p  incoming flit
- `link_v_i`  in  1  flit valid
- `link_ready_o`  out  1  flit accept; a flit transfers when `link_v_i & link_ready_o`
- `mem_resp_o`  out  mem_hdr_width_p+data_width_p  reassembled message, `{data, msg}`
- `mem_resp_v_o`  out  1  message valid
- `mem_resp_yumi_i`  in  1  consumer takes the message; legal only while `mem_resp_v_o`=1
- `src_cord_o`  out  cord_width_p  source coordinate of the current packet
- `src_cid_o`  out  cid_width_p  source cid of the current packet

## Operation
- Packet layout, LSB first: `cord`, `len`, `cid`, `src_cord`, `src_cid`, `msg`, `data`. Flit k fills buffer bits `[k*flit_width_p +: flit_width_p]`. The buffer is `max_flits_lp*flit_width_p` bits.
- FSM states:
  - `e_ready` (reset): `link_ready_o`=1. A transfer clears the buffer, writes flit 0, latches `len` from flit 0, and sets the counter to 1. If `len`=0, the next state is `e_out`; otherwise it is `e_recv`.
  - `e_recv`: `link_ready_o`=1. Each transfer writes flit[counter] and increments the counter. On the transfer where counter == `len`, the next state is `e_out`.
  - `e_out`: `mem_resp_v_o`=1 and `link_ready_o`=0 (see Configuration). `mem_resp_yumi_i` returns the FSM to `e_ready`.
- Buffer bits not written by the current packet read as 0. This covers small-size and ack responses, whose `data` is zero above the transmitted bytes.
- `len` > `max_flits_lp-1`: flits with index ≥ `max_flits_lp` are consumed and discarded, and the counter continues to count up to `len`. The counter is `len_width_p` bits wide and does not wrap before reaching `len`.
- `msg_type` and `size` are not inspected; framing depends only on `len`.
- `mem_resp_o`, `src_cord_o` and `src_cid_o` are driven directly from the buffer. They are meaningful only while `mem_resp_v_o`=1.

## Timing
- Reset values: state `e_ready`, counter 0, buffer 0, `mem_resp_v_o`=0, `link_ready_o`=1. `mem_resp_o`, `src_cord_o` and `src_cid_o` all read 0.
- An asynchronous reset assertion mid-packet or mid-output discards the partial packet immediately. No output is produced for it.
- `mem_resp_v_o` rises on the cycle after the transfer of the last flit (flit `len`).
- With a gap-free link, minimum packet-to-packet period is `len+2` cycles without the macro and `len+1` cycles with it.
- `link_ready_o` is registered state only (no combinational path from `link_v_i`), except as noted under Configuration.

## Configuration
- `BP_ME_WH_DECODE_OVERLAP_EN`:
  - Defined: in `e_out`, `link_ready_o = mem_resp_yumi_i` (combinational). A flit accepted in the same cycle as yumi is treated as flit 0 of the next packet: the buffer is cleared and loaded, and the FSM goes to `e_recv`, or stays in `e_out` if the new `len`=0. `mem_resp_v_o` remains 1 in that case.
  - Undefined: `link_ready_o`=0 throughout `e_out`.

## Test plan
Bench configuration: `flit_width_p`=64, `cord_width_p`=7, `cid_width_p`=2, `len_width_p`=4, `mem_hdr_width_p`=64, `data_width_p`=512. This gives `pkt_width_lp`=598 and `max_flits_lp`=10.
- Ack packet (`len`=1, 2 flits, no stall), yumi on the first valid cycle → `mem_resp_v_o` high exactly 1 cycle, 1 cycle after flit 1; `mem_resp_o` data=0; msg and src_cord/src_cid match the sent values.
- 8-byte read response (`len`=2, data 0xDEADBEEF_CAFEF00D) preceded by a 64-byte packet with all-ones data → data[63:0] matches, data[511:64]=0.
- 64-byte response (`len`=9), `link_v_i` toggling every other cycle, yumi held off 5 cycles → full 512-bit data exact; `mem_resp_v_o` stays 1 for 6 cycles; `link_ready_o`=0 throughout (macro undefined).
- `reset_i` asserted after flit 4 of a `len`=9 packet, then a new `len`=1 packet → no output for the aborted packet; the second packet is decoded correctly.
- Malformed `len`=12 → 13 flits consumed; output valid after flit 12; flits 10–12 ignored.
- With `BP_ME_WH_DECODE_OVERLAP_EN`, back-to-back `len`=1 packets with yumi in the first valid cycle → output period 2 cycles; the second message is correct.
